input_debounce_sync: RTL
========================

// Module: input_debounce_sync
// PURPOSE
//  Conditions raw asynchronous switch/pin inputs before they reach the CPU input port register.
//  Each bit passes through a synchroniser. A debounce FSM then requires the whole word to hold
//  stable for DEBOUNCE_CYCLES samples. It then presents the word on DataOut with a single-cycle
//  Write strobe. DataOut/Write drive the input port register's Input/Write pins directly.
// PARAMETERS
//  WIDTH_DATA_LENGTH  8   width of the raw input word and DataOut
//  SYNC_STAGES        2   synchroniser flops per bit; legal range >= 2
//  DEBOUNCE_CYCLES    16  consecutive stable samples needed before commit; legal range >= 1
// PORTS
//  Clk      input   1                   system clock, all state on rising edge
//  Rst      input   1                   asynchronous, active-low reset
//  RawIn    input   WIDTH_DATA_LENGTH   raw external pins, asynchronous to Clk
//  DataOut  output  WIDTH_DATA_LENGTH   last committed debounced word (registered)
//  Write    output  1                   one-cycle strobe: DataOut just updated (registered)
// BEHAVIOUR
//  Reset
//   - Clock is Clk; reset is Rst, asynchronous, active-low.
//   - Rst=0 immediately clears all synchroniser flops, candidate, committed, cnt and DataOut
//     to 0; Write=0; state=IDLE.
//   - Reset mid-operation aborts any count in progress; no Write is produced for the aborted word.
//  Synchroniser
//   - SYNC_STAGES-deep shift per bit; sync_q = last stage. Only sync_q feeds the FSM.
//  Internal state
//   - committed: equals DataOut.
//   - candidate: WIDTH_DATA_LENGTH-bit register.
//   - cnt: width $clog2(DEBOUNCE_CYCLES) with a minimum of 1; saturating, never wraps.
//  FSM states and transitions
//   - IDLE: if sync_q != committed then candidate<=sync_q, cnt<=0, go to COUNT; else stay.
//   - COUNT, evaluated in this priority order:
//     - sync_q == committed: go to IDLE (glitch rejected, no Write).
//     - sync_q != candidate: candidate<=sync_q, cnt<=0, stay in COUNT (restart).
//     - cnt == DEBOUNCE_CYCLES-1: DataOut<=candidate, committed<=candidate, Write<=1, go to COMMIT.
//     - otherwise: cnt<=cnt+1.
//   - COMMIT: Write<=0, go to IDLE. sync_q is ignored for this one cycle; IDLE re-evaluates it.
//  Write strobe
//   - Write is high for exactly one cycle per commit; never high on two consecutive cycles.
//   - DataOut changes only on the edge that raises Write.
//  Latency
//   - RawIn changes, with setup met before edge E1, then holds.
//   - Write=1 and DataOut=new value appear after edge E(SYNC_STAGES+DEBOUNCE_CYCLES+1).
//   - Defaults: edge E19.
//  Boundary conditions
//   - Multi-bit change arriving skewed across edges: the restart rule makes it commit once,
//     with the final value.
//   - Input returning to the committed value before the count expires: no Write.
//   - RawIn non-zero while Rst is released: commits like any change from 0, same latency.
//   - A new change during COMMIT is seen in IDLE on the following edge; latency +1 at most.
//   - RawIn == committed forever: FSM stays in IDLE, Write stays 0.
// TESTING
//  - Reset: Rst=0 with RawIn=8'hFF -> DataOut=8'h00, Write=0 asynchronously.
//    Release -> Write pulses at E19 with DataOut=8'hFF.
//  - Clean step: RawIn 8'h00->8'h3C before E1, then held -> Write=1 only after E19.
//    DataOut=8'h3C; Write=0 after E20.
//  - Glitch: RawIn=8'h01 for 5 cycles, then back to 8'h00 -> no Write and DataOut stays 8'h00
//    for 40 cycles.
//  - Bounce: toggle bit0 8 times at 3-cycle spacing, ending at 8'h01 -> exactly one Write.
//    Write comes 19 edges after the last toggle; DataOut=8'h01.
//  - Reset mid-count: step to 8'hA5, assert Rst at E10 -> no Write, DataOut=8'h00.
//    After release, Write at E19 relative to release with 8'hA5.
//  - Back-to-back: 8'h00->8'h11, then 8'h22 one cycle after the Write -> two single-cycle Writes.
//    Values 8'h11 then 8'h22; gap 19 or 20 edges.

Source files
------------

// File: rtl/input_debounce_sync.sv
// -----------------------------------------------------------------------------
// input_debounce_sync
//   Conditions raw asynchronous switch/pin inputs for the CPU input port
//   register. Every bit goes through a SYNC_STAGES-deep synchroniser. A
//   debounce FSM then requires the whole synchronised word to hold for
//   DEBOUNCE_CYCLES samples before it commits. A commit loads DataOut and
//   pulses Write for one cycle.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst      in   asynchronous reset, active low
//   RawIn    in   [WIDTH_DATA_LENGTH] raw pins, asynchronous to Clk
//   DataOut  out  [WIDTH_DATA_LENGTH] last committed word (registered)
//   Write    out  one-cycle strobe, high on the cycle DataOut updates
// -----------------------------------------------------------------------------
module input_debounce_sync #(
    parameter int WIDTH_DATA_LENGTH = 8,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] RawIn,
    output logic [WIDTH_DATA_LENGTH-1:0] DataOut,
    output logic                         Write
);

    localparam int W  = WIDTH_DATA_LENGTH;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // ---------------- synchroniser ----------------
    // Stage 0 is the metastability-exposed flop; only the last stage is used.
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  sync_out;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], RawIn};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ---------------- debounce FSM ----------------
    logic [1:0]    state_q, state_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  comm_q, comm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        comm_d  = comm_q;
        cnt_d   = cnt_q;
        write_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_out != comm_q) begin
                    cand_d  = sync_out;
                    cnt_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync_out == comm_q) begin
                    // input fell back to the committed word: treat as a glitch
                    state_d = ST_IDLE;
                end else if (sync_out != cand_q) begin
                    // any further change restarts the window with the newest
                    // value, so skewed multi-bit edges commit only once
                    cand_d = sync_out;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    comm_d  = cand_q;
                    write_d = 1'b1;
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                // one blind cycle keeps Write from ever being high twice in a row
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            comm_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            comm_q  <= comm_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
        end
    end

    // The committed register is the output register.
    assign DataOut = comm_q;
    assign Write   = write_q;

endmodule
